// File: rtl/sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// sipo_frame_receiver
//   Serial-in/parallel-out frame receiver. A Start strobe opens a frame and one
//   bit is sampled on every clock where the bit-valid qualifier is high. After
//   WIDTH sampled bits the assembled word is published on o_qout together with
//   a one-cycle o_qvalid pulse. A Start while a frame is in progress aborts the
//   partial frame, reports it on o_frame_err and opens a new frame.
//
// Parameters
//   WIDTH      bits per frame (>= 2)
//   MSB_FIRST  1: first received bit lands in o_qout[WIDTH-1]
//              0: first received bit lands in o_qout[0]
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_start      frame-start strobe; a bit sampled in the same cycle is the
//                first bit of the frame
//   i_sin        serial data
//   i_sin_en     bit-valid qualifier for i_sin
//   o_qout       last completed word, held until the next frame completes
//   o_qvalid     one-cycle pulse, o_qout updated this cycle
//   o_busy       high while a frame is in progress
//   o_frame_err  one-cycle pulse, a frame was aborted by a Start
// -----------------------------------------------------------------------------
module sipo_frame_receiver #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_sin,
    input  logic             i_sin_en,
    output logic [WIDTH-1:0] o_qout,
    output logic             o_qvalid,
    output logic             o_busy,
    output logic             o_frame_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_qout;
    logic             r_qvalid;
    logic             r_busy;
    logic             r_frame_err;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_qout_nxt;
    logic             w_qvalid_nxt;
    logic             w_frame_err_nxt;
    logic             w_last_bit;

    // Shift one bit into the assembly register in the configured bit order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                  input logic            b);
        logic [WIDTH-1:0] res;
        if (MSB_FIRST != 0) begin
            res = {sr[WIDTH-2:0], b};
        end else begin
            res = {b, sr[WIDTH-1:1]};
        end
        return res;
    endfunction

    // The bit being sampled now completes the frame.
    assign w_last_bit = (r_count == CW'(WIDTH - 1));

    // Next-state, shift and output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_sr_nxt        = r_sr;
        w_qout_nxt      = r_qout;
        w_qvalid_nxt    = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    // Open a frame; a bit qualified in the Start cycle is its first bit.
                    w_state_nxt = S_RECV;
                    if (i_sin_en) begin
                        w_sr_nxt    = shift_in({WIDTH{1'b0}}, i_sin);
                        w_count_nxt = CW'(1);
                    end else begin
                        w_sr_nxt    = {WIDTH{1'b0}};
                        w_count_nxt = {CW{1'b0}};
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_RECV: begin
                if (i_start) begin
                    // Abort takes priority even over a completing bit: the
                    // partial word is dropped and a new frame begins.
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = S_RECV;
                    if (i_sin_en) begin
                        w_sr_nxt    = shift_in({WIDTH{1'b0}}, i_sin);
                        w_count_nxt = CW'(1);
                    end else begin
                        w_sr_nxt    = {WIDTH{1'b0}};
                        w_count_nxt = {CW{1'b0}};
                    end
                end else if (i_sin_en) begin
                    if (w_last_bit) begin
                        // Publish on the same edge that samples the final bit.
                        w_qout_nxt   = shift_in(r_sr, i_sin);
                        w_qvalid_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                        w_count_nxt  = {CW{1'b0}};
                        w_sr_nxt     = {WIDTH{1'b0}};
                    end else begin
                        w_sr_nxt    = shift_in(r_sr, i_sin);
                        w_count_nxt = r_count + CW'(1);
                    end
                end else begin
                    // Gap in the bit stream: hold everything.
                    w_state_nxt = S_RECV;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = {CW{1'b0}};
                w_sr_nxt    = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= {CW{1'b0}};
            r_sr        <= {WIDTH{1'b0}};
            r_qout      <= {WIDTH{1'b0}};
            r_qvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_sr        <= w_sr_nxt;
            r_qout      <= w_qout_nxt;
            r_qvalid    <= w_qvalid_nxt;
            r_busy      <= (w_state_nxt == S_RECV);
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign o_qout      = r_qout;
    assign o_qvalid    = r_qvalid;
    assign o_busy      = r_busy;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_receiver
//   Directed bench for sipo_frame_receiver. Two instances share the stimulus:
//   one MSB-first, one LSB-first. Bits are always transmitted starting with
//   bit 7 of the frame constant, so the MSB-first instance must reproduce the
//   constant and the LSB-first instance its bit reversal.
// -----------------------------------------------------------------------------
module tb_sipo_frame_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sin;
    logic       sin_en;

    logic [7:0] qout_m;
    logic       qv_m;
    logic       busy_m;
    logic       fe_m;
    logic [7:0] qout_l;
    logic       qv_l;
    logic       busy_l;
    logic       fe_l;

    int n_checks = 0;
    int n_errors = 0;
    int qv_cnt_m = 0;
    int qv_cnt_l = 0;
    int fe_cnt_m = 0;
    int fe_cnt_l = 0;

    logic [7:0] exp_q_m = 8'h00;
    logic [7:0] exp_q_l = 8'h00;

    int qv_base;
    int fe_base;

    sipo_frame_receiver #(.WIDTH(8), .MSB_FIRST(1)) u_dut_msb (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_sin       (sin),
        .i_sin_en    (sin_en),
        .o_qout      (qout_m),
        .o_qvalid    (qv_m),
        .o_busy      (busy_m),
        .o_frame_err (fe_m)
    );

    sipo_frame_receiver #(.WIDTH(8), .MSB_FIRST(0)) u_dut_lsb (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_sin       (sin),
        .i_sin_en    (sin_en),
        .o_qout      (qout_l),
        .o_qvalid    (qv_l),
        .o_busy      (busy_l),
        .o_frame_err (fe_l)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k] = d[7-k];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are observed 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (qv_m === 1'b1) qv_cnt_m++;
        if (qv_l === 1'b1) qv_cnt_l++;
        if (fe_m === 1'b1) fe_cnt_m++;
        if (fe_l === 1'b1) fe_cnt_l++;
    endtask

    task automatic drive(input logic s, input logic b, input logic e);
        start  = s;
        sin    = b;
        sin_en = e;
        tick();
    endtask

    // Send one 8-bit frame, bit 7 first, Start on the first bit.
    task automatic send_frame(input logic [7:0] d, input bit gaps, input logic exp_ferr);
        for (int i = 0; i < 8; i++) begin
            if (gaps && i > 0) begin
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    drive(1'b0, 1'b1, 1'b0);
                    check("gap_busy", {31'd0, busy_m & busy_l}, 32'd1);
                    check("gap_qvalid", {31'd0, qv_m | qv_l}, 32'd0);
                end
            end
            drive((i == 0), d[7-i], 1'b1);
            if (i == 0) begin
                check("start_ferr_m", {31'd0, fe_m}, {31'd0, exp_ferr});
                check("start_ferr_l", {31'd0, fe_l}, {31'd0, exp_ferr});
            end
            if (i < 7) begin
                check("mid_busy", {31'd0, busy_m & busy_l}, 32'd1);
                check("mid_qvalid", {31'd0, qv_m | qv_l}, 32'd0);
                check("mid_qout_hold_m", {24'd0, qout_m}, {24'd0, exp_q_m});
                check("mid_qout_hold_l", {24'd0, qout_l}, {24'd0, exp_q_l});
            end else begin
                exp_q_m = d;
                exp_q_l = rev8(d);
                check("done_qvalid_m", {31'd0, qv_m}, 32'd1);
                check("done_qvalid_l", {31'd0, qv_l}, 32'd1);
                check("done_qout_m", {24'd0, qout_m}, {24'd0, exp_q_m});
                check("done_qout_l", {24'd0, qout_l}, {24'd0, exp_q_l});
                check("done_busy", {31'd0, busy_m | busy_l}, 32'd0);
                check("done_ferr", {31'd0, fe_m | fe_l}, 32'd0);
            end
        end
        start  = 1'b0;
        sin_en = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        drive(1'b0, 1'b0, 1'b0);
        check({tag, "_qvalid"}, {31'd0, qv_m | qv_l}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_m | busy_l}, 32'd0);
        check({tag, "_qout_m"}, {24'd0, qout_m}, {24'd0, exp_q_m});
        check({tag, "_qout_l"}, {24'd0, qout_l}, {24'd0, exp_q_l});
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        sin    = 1'b0;
        sin_en = 1'b0;
        tick();
        tick();
        check("rst_qout", {16'd0, qout_m, qout_l}, 32'd0);
        check("rst_flags", {24'd0, qv_m, qv_l, busy_m, busy_l, fe_m, fe_l, 2'b00}, 32'd0);
        rst_n = 1'b1;
        // Start=0 with bits present must be ignored in IDLE.
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        check("idle_ignore_busy", {31'd0, busy_m | busy_l}, 32'd0);

        // Tests 1 and 2: bits 0,1,0,0,1,0,1,0 back to back.
        qv_base = qv_cnt_m;
        send_frame(8'h4A, 1'b0, 1'b0);
        check("t1_qout_msb", {24'd0, qout_m}, 32'h0000_004A);
        check("t2_qout_lsb", {24'd0, qout_l}, 32'h0000_0052);
        idle_check("t1_after");
        check("t1_single_qvalid", qv_cnt_m - qv_base, 32'd1);

        // Test 3: 8'hDA with 1-3 cycle gaps.
        qv_base = qv_cnt_l;
        send_frame(8'hDA, 1'b1, 1'b0);
        idle_check("t3_after");
        check("t3_single_qvalid", qv_cnt_l - qv_base, 32'd1);

        // Test 4: 5 bits, then a restarting Start carrying 8'hEF.
        qv_base = qv_cnt_m;
        fe_base = fe_cnt_m;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        check("t4_partial_busy", {31'd0, busy_m}, 32'd1);
        send_frame(8'hEF, 1'b0, 1'b1);
        idle_check("t4_after");
        check("t4_one_ferr", fe_cnt_m - fe_base, 32'd1);
        check("t4_one_qvalid", qv_cnt_m - qv_base, 32'd1);

        // Test 5: reset after 4 bits, then qualified bits without Start.
        qv_base = qv_cnt_m + qv_cnt_l;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        exp_q_m = 8'h00;
        exp_q_l = 8'h00;
        check("t5_rst_qout", {16'd0, qout_m, qout_l}, 32'd0);
        check("t5_rst_flags", {28'd0, qv_m | qv_l, busy_m | busy_l, fe_m | fe_l, 1'b0}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1);
        end
        check("t5_no_qvalid", (qv_cnt_m + qv_cnt_l) - qv_base, 32'd0);
        idle_check("t5_after");

        // Test 6: 8'hFA then 8'h11 with no dead cycle.
        qv_base = qv_cnt_m;
        send_frame(8'hFA, 1'b0, 1'b0);
        check("t6_first_m", {24'd0, qout_m}, 32'h0000_00FA);
        check("t6_first_l", {24'd0, qout_l}, 32'h0000_005F);
        send_frame(8'h11, 1'b0, 1'b0);
        check("t6_second_m", {24'd0, qout_m}, 32'h0000_0011);
        check("t6_second_l", {24'd0, qout_l}, 32'h0000_0088);
        idle_check("t6_after");
        check("t6_two_qvalid", qv_cnt_m - qv_base, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
